// File: rtl/tpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tpu_seq
// Description : Job sequencer that streams A/B operands into a memory-mapped
//               TPU, clears C, issues a matmul, then streams C out.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_seq #(
  parameter int DIM         = 8,
  parameter int DATAW       = 64,
  parameter int ADDRW       = 16,
  parameter int MATMUL_WAIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CLR_C  = 3'd3,
    S_MATMUL = 3'd4,
    S_WAIT   = 3'd5,
    S_READ_C = 3'd6
  } state_t;

  localparam logic [4:0] c_ab_last   = 5'(DIM - 1);
  localparam logic [4:0] c_c_last    = 5'(2 * DIM - 1);
  localparam logic [4:0] c_c_end     = 5'(2 * DIM);
  localparam logic [4:0] c_wait_last = (MATMUL_WAIT <= 1) ? 5'd0 : 5'(MATMUL_WAIT - 1);

  state_t             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [DATAW-1:0]   out_data_q, out_data_d;

  logic [11:0]        w_addr;
  logic [11:0]        w_c_addr;
  logic               w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 5'd0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // C is laid out as two half-row words per row
  assign w_c_addr = 12'h300 + {4'b0000, idx_q[4:1], 4'b0000} + {8'h00, idx_q[0], 3'b000};
  assign w_accept = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    w_addr      = 12'h000;
    tpu_r_w     = 1'b0;
    tpu_wdata   = '0;
    in_ready    = 1'b0;

    if (w_accept) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          idx_d   = 5'd0;
        end
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_addr    = 12'h100 + {4'b0000, idx_q, 3'b000};
          tpu_r_w   = 1'b1;
          tpu_wdata = in_data;
          idx_d     = idx_q + 5'd1;
          if (idx_q == c_ab_last) begin
            state_d = S_LOAD_B;
            idx_d   = 5'd0;
          end
        end
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_addr    = 12'h200;
          tpu_r_w   = 1'b1;
          tpu_wdata = in_data;
          idx_d     = idx_q + 5'd1;
          if (idx_q == c_ab_last) begin
            state_d = S_CLR_C;
            idx_d   = 5'd0;
          end
        end
      end
      S_CLR_C: begin
        w_addr  = w_c_addr;
        tpu_r_w = 1'b1;
        idx_d   = idx_q + 5'd1;
        if (idx_q == c_c_last) begin
          state_d = S_MATMUL;
          idx_d   = 5'd0;
        end
      end
      S_MATMUL: begin
        w_addr  = 12'h400;
        tpu_r_w = 1'b1;
        state_d = S_WAIT;
        idx_d   = 5'd0;
      end
      S_WAIT: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == c_wait_last) begin
          state_d = S_READ_C;
          idx_d   = 5'd0;
        end
      end
      S_READ_C: begin
        // idx == 2*DIM means every word is captured; drain the last one
        if (idx_q != c_c_end) begin
          if (!out_valid_q || out_ready) begin
            w_addr      = w_c_addr;
            out_data_d  = tpu_rdata;
            out_valid_d = 1'b1;
            out_last_d  = (idx_q == c_c_last);
            idx_d       = idx_q + 5'd1;
          end
        end else if (w_accept) begin
          state_d = S_IDLE;
          idx_d   = 5'd0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

  assign tpu_addr  = ADDRW'(w_addr);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_seq.sv
`default_nettype none
// Bench for tpu_seq: emulates the TPU memory map, predicts the bus trace and
// the C stream from plain matrix arithmetic, and compares every cycle.
module tb_tpu_seq;
  localparam int DIM         = 8;
  localparam int DATAW       = 64;
  localparam int ADDRW       = 16;
  localparam int MATMUL_WAIT = 32;
  localparam int NW          = 2 * DIM;

  typedef logic [63:0] mat_t [DIM];
  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [63:0] data;
  } bus_ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [15:0] tpu_addr;
  logic        tpu_r_w;
  logic [63:0] tpu_wdata, tpu_rdata;

  tpu_seq #(.DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .MATMUL_WAIT(MATMUL_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bus_ev_t     exp_bus [$];
  logic [63:0] exp_out [$];
  logic [63:0] got [NW];
  int acc_cnt = 0, done_cnt = 0, n_in = 0;
  int last_in_cyc = 0, mm_cyc = 0, last_acc_cyc = 0;
  bit first_clr_pending = 0, first_rd_pending = 0;
  bit hold_prev = 0, hold_last = 0;
  logic [63:0] hold_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j], 8-bit operands, 16-bit results;
  // word 2i carries elements 0..3 of row i, word 2i+1 elements 4..7
  function automatic logic [63:0] c_word(input mat_t a, input mat_t b, input int w);
    logic [63:0] r;
    logic [15:0] s;
    int i, j;
    r = '0;
    i = w / 2;
    for (int jj = 0; jj < 4; jj++) begin
      j = (w % 2) * 4 + jj;
      s = '0;
      for (int k = 0; k < DIM; k++)
        s = s + 16'(a[i][8*k +: 8]) * 16'(b[k][8*j +: 8]);
      r[16*jj +: 16] = s;
    end
    return r;
  endfunction

  // TPU emulation: A rows at 0x100.., B rows streamed into 0x200, C at
  // 0x300.., matmul accumulates A*B into C on a write to 0x400
  mat_t        a_mem, b_mem;
  logic [63:0] c_mem [NW];
  int          b_cnt;

  always_comb begin
    tpu_rdata = '0;
    if (tpu_addr[15:7] == 9'h006 && tpu_addr[2:0] == 3'b000)
      tpu_rdata = c_mem[tpu_addr[6:3]];
  end

  initial begin
    for (int w = 0; w < NW; w++) c_mem[w] = 64'hDEAD_BEEF_0000_0000 | 64'(w);
    for (int i = 0; i < DIM; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    b_cnt = 0;
    forever begin
      @(negedge clk);
      if (tpu_r_w === 1'b1) begin
        if (tpu_addr[15:6] == 10'h004 && tpu_addr[2:0] == 3'b000)
          a_mem[tpu_addr[5:3]] = tpu_wdata;
        else if (tpu_addr == 16'h0200) begin
          b_mem[b_cnt] = tpu_wdata;
          b_cnt = (b_cnt + 1) % DIM;
        end else if (tpu_addr[15:7] == 9'h006 && tpu_addr[2:0] == 3'b000)
          c_mem[tpu_addr[6:3]] = tpu_wdata;
        else if (tpu_addr == 16'h0400) begin
          for (int w = 0; w < NW; w++) c_mem[w] = c_mem[w] + c_word(a_mem, b_mem, w);
          b_cnt = 0;
        end
      end
    end
  end

  // Compare process
  initial begin
    bus_ev_t ev;
    logic [63:0] ew;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
      end else begin
        if (tpu_r_w == 1'b0 && tpu_addr == 16'h0000) begin
          check("idle_wdata", tpu_wdata, 64'h0);
        end else begin
          if (exp_bus.size() == 0) begin
            fail_now("bus_extra", $sformatf("access addr=%h rw=%b, none required", tpu_addr, tpu_r_w));
          end else begin
            ev = exp_bus.pop_front();
            check("bus_addr", 64'(tpu_addr), 64'(ev.addr));
            check("bus_rw", 64'(tpu_r_w), 64'(ev.rw));
            check("bus_wdata", tpu_wdata, ev.data);
          end
          if (tpu_r_w && tpu_addr == 16'h0300 && first_clr_pending) begin
            check("clr_start_cycle", 64'(cyc), 64'(last_in_cyc + 1));
            first_clr_pending = 0;
          end
          if (tpu_r_w && tpu_addr == 16'h0400) mm_cyc = cyc;
          if (!tpu_r_w && tpu_addr == 16'h0300 && first_rd_pending) begin
            check("read_start_cycle", 64'(cyc), 64'(mm_cyc + MATMUL_WAIT + 1));
            first_rd_pending = 0;
          end
        end
        if (in_valid && in_ready) begin
          last_in_cyc = cyc;
          n_in++;
        end
        if (hold_prev) begin
          check("hold_valid", 64'(out_valid), 64'h1);
          check("hold_data", out_data, hold_data);
          check("hold_last", 64'(out_last), 64'(hold_last));
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            fail_now("out_extra", $sformatf("word %h accepted, none required", out_data));
          end else begin
            ew = exp_out.pop_front();
            check("out_data", out_data, ew);
            check("out_last", 64'(out_last), 64'(exp_out.size() == 0));
          end
          if (acc_cnt < NW) got[acc_cnt] = out_data;
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        if (done === 1'b1) begin
          check("done_cycle", 64'(cyc), 64'(last_acc_cyc + 1));
          done_cnt++;
        end
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
      end
    end
  end

  task automatic push_ev(input logic [15:0] addr, input logic rw, input logic [63:0] data);
    bus_ev_t ev;
    ev.addr = addr;
    ev.rw   = rw;
    ev.data = data;
    exp_bus.push_back(ev);
  endtask

  task automatic plan_job(input mat_t a, input mat_t b);
    for (int i = 0; i < DIM; i++) push_ev(16'h0100 + 16'(8 * i), 1'b1, a[i]);
    for (int i = 0; i < DIM; i++) push_ev(16'h0200, 1'b1, b[i]);
    for (int w = 0; w < NW; w++) push_ev(16'h0300 + 16'(8 * w), 1'b1, 64'h0);
    push_ev(16'h0400, 1'b1, 64'h0);
    for (int w = 0; w < NW; w++) push_ev(16'h0300 + 16'(8 * w), 1'b0, 64'h0);
    for (int w = 0; w < NW; w++) exp_out.push_back(c_word(a, b, w));
    first_clr_pending = 1;
    first_rd_pending  = 1;
    acc_cnt           = 0;
  endtask

  task automatic run_job(input mat_t a, input mat_t b, input bit gaps, input int bp_len,
                         input bit glitch, input bit abort);
    int t, d0, n0;
    bit bp_done, gl_done, timed_out;
    plan_job(a, b);
    d0 = done_cnt;
    n0 = n_in;
    timed_out = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NW && !timed_out; i++) begin
      in_valid = 1'b1;
      in_data  = (i < DIM) ? a[i] : b[i - DIM];
      if (glitch && i == DIM + 2) start = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 100);
      if (!in_ready) begin
        fail_now("in_timeout", $sformatf("input word %0d never accepted", i));
        timed_out = 1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = 64'hFFFF_0000_FFFF_0000 ^ 64'(i);
      if (gaps) begin
        @(posedge clk); #1;
      end
    end
    if (timed_out) return;

    if (abort) begin
      t = 0;
      while (exp_bus.size() > NW && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (exp_bus.size() > NW) fail_now("matmul_timeout", "matmul write never seen");
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_bus.delete();
      exp_out.delete();
      first_clr_pending = 0;
      first_rd_pending  = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_valid", 64'(out_valid), 64'h0);
      check("abort_addr", 64'(tpu_addr), 64'h0);
      repeat (40) @(posedge clk);
      #1;
      return;
    end

    t = 0;
    bp_done = (bp_len == 0);
    gl_done = !glitch;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0;
      if (!bp_done && acc_cnt >= 3) begin
        out_ready = 1'b0;
        repeat (bp_len) @(posedge clk);
        #1;
        out_ready = 1'b1;
        bp_done   = 1;
      end
      if (!gl_done && acc_cnt >= 6) begin
        start   = 1'b1;
        gl_done = 1;
      end
    end
    start = 1'b0;
    if (done_cnt == d0) fail_now("done_timeout", "job never signalled done");
    check("out_words_left", 64'(exp_out.size()), 64'h0);
    check("bus_events_left", 64'(exp_bus.size()), 64'h0);
    check("done_pulses", 64'(done_cnt - d0), 64'h1);
    check("in_transfers", 64'(n_in - n0), 64'(NW));
    @(negedge clk);
    check("busy_after", 64'(busy), 64'h0);
    check("done_after", 64'(done), 64'h0);
    check("valid_after", 64'(out_valid), 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mat_t ida, brow, ones, ra, rb;
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h0BAD_0BAD_0BAD_0BAD;
    out_ready = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      ida[i]  = 64'h1 << (8 * i);
      brow[i] = {8{8'(i + 1)}};
      ones[i] = {8{8'h01}};
    end
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_last", 64'(out_last), 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_tpu_addr", 64'(tpu_addr), 64'h0);
    check("rst_tpu_r_w", 64'(tpu_r_w), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);

    // identity A: C reproduces B as half-rows
    run_job(ida, brow, 1'b0, 0, 1'b0, 1'b0);
    check("lit_id_w0", got[0], 64'h0001_0001_0001_0001);
    check("lit_id_w6", got[6], 64'h0004_0004_0004_0004);
    check("lit_id_w15", got[15], 64'h0008_0008_0008_0008);

    // all-ones A with input gaps: every element is 1+2+...+8 = 36
    run_job(ones, brow, 1'b1, 0, 1'b0, 1'b0);
    check("lit_ones_w9", got[9], 64'h0024_0024_0024_0024);

    for (int i = 0; i < DIM; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
    end
    run_job(ra, rb, 1'b0, 5, 1'b1, 1'b0);

    run_job(rb, ra, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < DIM; i++) ra[i] = {$urandom, $urandom};
    run_job(ra, rb, 1'b1, 0, 1'b0, 1'b0);
    run_job(ida, brow, 1'b0, 2, 1'b0, 1'b0);
    check("lit_b2b_w15", got[15], 64'h0008_0008_0008_0008);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
